// File: rtl/flush_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flush_redirect_ctrl_pkg
//  Brief    : Shared types, vector constants and target-select helper for the
//             write-back flush / pre-IF redirect controller.
//  Revision : 1.0
// ============================================================================
package flush_redirect_ctrl_pkg;

  // Exception entry points (boot-exception-vector space)
  localparam logic [31:0] C_EXC_VEC    = 32'hBFC0_0380;
  localparam logic [31:0] C_REFILL_VEC = 32'hBFC0_0200;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } state_e;

  // Redirect target for a WB event; exception beats ERET beats TLB refetch.
  // The refetch target wraps modulo 2^32.
  function automatic logic [31:0] flush_target(
    input logic        exc,
    input logic        refill,
    input logic        eret,
    input logic [31:0] epc,
    input logic [31:0] pc,
    input logic [31:0] exc_vec,
    input logic [31:0] refill_vec
  );
    logic [31:0] tgt;
    if (exc) begin
      tgt = refill ? refill_vec : exc_vec;
    end else if (eret) begin
      tgt = epc;
    end else begin
      tgt = pc + 32'd4;
    end
    return tgt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flush_redirect_ctrl_inflight_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : flush_redirect_ctrl_inflight_cnt
//  Brief    : Up/down counter of in-flight fetch requests with optional
//             parallel load; simultaneous inc and dec cancel.
//  Revision : 1.0
// ============================================================================
module flush_redirect_ctrl_inflight_cnt #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: a load takes precedence over the inc/dec pair
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else begin
      cnt_d = cnt_q + CW'(inc_i) - CW'(dec_i);
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Saturation checks: never above MAX, never decremented through zero
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (cnt_d <= CW'(MAX));
      assert (!(!load_i && dec_i && !inc_i && (cnt_q == '0)));
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/flush_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : flush_redirect_ctrl
//  Brief    : Same-cycle pipeline flush for WB exception / ERET / TLB refetch,
//             held valid/ready redirect toward pre-IF, and stale fetch-response
//             tracking so responses to pre-flush requests are dropped.
//  Revision : 1.0
// ============================================================================
module flush_redirect_ctrl
  import flush_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC    = C_EXC_VEC,
  parameter logic [31:0] REFILL_VEC = C_REFILL_VEC,
  parameter int          MAX_OUTST  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_exc_i,
  input  logic        ws_refill_i,
  input  logic        ws_eret_i,
  input  logic        ws_tlb_flush_i,
  input  logic [31:0] ws_epc_i,
  input  logic [31:0] ws_pc_i,
  output logic        flush_out_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  input  logic        inst_req_fire_i,
  input  logic        inst_resp_fire_i,
  output logic        discard_resp_o,
  output logic        busy_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  state_e        state_q, state_d;
  logic [31:0]   redir_pc_q, redir_pc_d;
  logic          ev;
  logic          accept;
  logic [31:0]   target;
  logic [CW-1:0] outst_cnt;
  logic [CW-1:0] outst_next;
  logic [CW-1:0] discard_cnt;
  logic          discard_inc;

  assign ev          = ws_exc_i | ws_eret_i | ws_tlb_flush_i;
  assign flush_out_o = ev;
  assign accept      = (state_q == ST_REDIR) && redirect_ready_i;
  assign target      = flush_target(ws_exc_i, ws_refill_i, ws_eret_i, ws_epc_i, ws_pc_i,
                                    EXC_VEC, REFILL_VEC);

  // Redirect FSM: a new event always relatches, even on the accept cycle
  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    if (ev) begin
      state_d    = ST_REDIR;
      redir_pc_d = target;
    end else if (accept) begin
      state_d    = ST_IDLE;
    end
  end

  // FSM state and held redirect target
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign redirect_valid_o = (state_q == ST_REDIR);
  assign redirect_pc_o    = redir_pc_q;

  // Every request outstanding after this cycle is stale when an event fires
  assign outst_next     = outst_cnt + CW'(inst_req_fire_i) - CW'(inst_resp_fire_i);
  // Requests issued while the redirect is still pending are also stale
  assign discard_inc    = inst_req_fire_i && (state_q == ST_REDIR) && !accept;
  assign discard_resp_o = inst_resp_fire_i && (discard_cnt != '0);
  assign busy_o         = redirect_valid_o || (discard_cnt != '0);

  flush_redirect_ctrl_inflight_cnt #(
    .MAX (MAX_OUTST),
    .CW  (CW)
  ) u_outst_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (inst_req_fire_i),
    .dec_i      (inst_resp_fire_i),
    .cnt_o      (outst_cnt)
  );

  flush_redirect_ctrl_inflight_cnt #(
    .MAX (MAX_OUTST),
    .CW  (CW)
  ) u_discard_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (ev),
    .load_val_i (outst_next),
    .inc_i      (discard_inc),
    .dec_i      (discard_resp_o),
    .cnt_o      (discard_cnt)
  );

  // Stale responses can never outnumber responses still owed
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (discard_cnt <= outst_cnt);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flush_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flush_redirect_ctrl
//  Brief    : Scoreboard bench for flush_redirect_ctrl with a request-list
//             reference model (each outstanding fetch tagged stale or live).
//  Revision : 1.0
// ============================================================================
module tb_flush_redirect_ctrl;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_exc, ws_refill, ws_eret, ws_tlb_flush;
  logic [31:0] ws_epc, ws_pc;
  logic        flush_out, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic        inst_req_fire, inst_resp_fire, discard_resp, busy;

  always #5 clk = ~clk;

  flush_redirect_ctrl dut (
    .clk              (clk),
    .resetn           (resetn),
    .ws_exc_i         (ws_exc),
    .ws_refill_i      (ws_refill),
    .ws_eret_i        (ws_eret),
    .ws_tlb_flush_i   (ws_tlb_flush),
    .ws_epc_i         (ws_epc),
    .ws_pc_i          (ws_pc),
    .flush_out_o      (flush_out),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .redirect_ready_i (redirect_ready),
    .inst_req_fire_i  (inst_req_fire),
    .inst_resp_fire_i (inst_resp_fire),
    .discard_resp_o   (discard_resp),
    .busy_o           (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        flush;
    logic        rv;
    logic        busy;
    logic [31:0] pc;
  } cyc_t;

  cyc_t        cyc_q[$];   // per-cycle expectations
  logic [31:0] acc_q[$];   // expected target at each redirect handshake
  logic        disc_q[$];  // expected discard flag per response

  // Reference model: pending redirect plus ordered list of outstanding fetches
  logic        m_pend = 1'b0;
  logic [31:0] m_pc   = 32'h0;
  logic        m_out[$];

  function automatic logic [31:0] ref_target(input logic exc, refill, eret,
                                             input logic [31:0] epc, pc);
    if (exc)  return refill ? 32'hBFC0_0200 : 32'hBFC0_0380;
    if (eret) return epc;
    return pc + 32'd4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts the response of this cycle
  task automatic drive(input logic exc, refill, eret, tlb, input logic [31:0] epc, pc,
                       input logic rdy, req, resp);
    cyc_t c;
    int   stale;
    logic acc;
    logic ev;
    @(negedge clk);
    if (resp && m_out.size() == 0) resp = 1'b0;
    if (req && m_out.size() >= MAXO && !resp) req = 1'b0;
    ws_exc = exc; ws_refill = refill; ws_eret = eret; ws_tlb_flush = tlb;
    ws_epc = epc; ws_pc = pc; redirect_ready = rdy;
    inst_req_fire = req; inst_resp_fire = resp;
    ev = exc | eret | tlb;
    stale = 0;
    foreach (m_out[i]) if (m_out[i]) stale++;
    c.flush = ev; c.rv = m_pend; c.pc = m_pc; c.busy = m_pend || (stale > 0);
    cyc_q.push_back(c);
    acc = m_pend && rdy;
    if (acc) acc_q.push_back(m_pc);
    if (resp) disc_q.push_back(m_out.pop_front());
    if (req) m_out.push_back(m_pend && !acc);
    if (ev) begin
      foreach (m_out[i]) m_out[i] = 1'b1;
      m_pend = 1'b1;
      m_pc   = ref_target(exc, refill, eret, epc, pc);
    end else if (acc) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic idle(input logic rdy);
    drive(0, 0, 0, 0, 32'h0, 32'h0, rdy, 0, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 8; k++) begin
      if (m_out.size() != 0 || m_pend) drive(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response
  initial begin
    cyc_t c;
    forever begin
      @(negedge clk);
      #2;
      if (resetn) begin
        if (cyc_q.size() != 0) begin
          c = cyc_q.pop_front();
          check("flush_out", {31'h0, flush_out}, {31'h0, c.flush});
          check("redirect_valid", {31'h0, redirect_valid}, {31'h0, c.rv});
          check("busy", {31'h0, busy}, {31'h0, c.busy});
          if (c.rv) check("held_pc", redirect_pc, c.pc);
        end
        if (redirect_valid && redirect_ready) begin
          if (acc_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL accept: got unexpected handshake pc %h expected none", redirect_pc);
          end else begin
            check("accept_pc", redirect_pc, acc_q.pop_front());
          end
        end
        if (inst_resp_fire) begin
          if (disc_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL discard: got response with no expectation, expected none");
          end else begin
            check("discard_resp", {31'h0, discard_resp}, {31'h0, disc_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rv"}, {31'h0, redirect_valid}, 32'h0);
    check({tag, "_pc"}, redirect_pc, 32'h0);
    check({tag, "_discard"}, {31'h0, discard_resp}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_flush"}, {31'h0, flush_out}, 32'h0);
  endtask

  initial begin
    resetn = 1'b0;
    ws_exc = 0; ws_refill = 0; ws_eret = 0; ws_tlb_flush = 0;
    ws_epc = 0; ws_pc = 0; redirect_ready = 0; inst_req_fire = 0; inst_resp_fire = 0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("por");
    @(negedge clk) resetn = 1'b1;

    // Reset in the middle of a redirect with two stale fetches
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 32'h1234_5678, 0, 0, 0, 0);
    idle(0);
    #3;
    resetn = 1'b0;
    inst_resp_fire = 1'b1;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    #1 check_all_zero("held_rst");
    m_pend = 1'b0; m_pc = 32'h0; m_out.delete();
    @(negedge clk);
    inst_resp_fire = 1'b0;
    resetn = 1'b1;
    idle(0);

    // ERET held for three not-ready cycles, then accepted
    drive(0, 0, 1, 0, 32'hBFC0_0100, 0, 0, 0, 0);
    repeat (3) idle(0);
    idle(1);
    idle(0);

    // Exception beats ERET; refill vector, then general vector
    drive(1, 1, 1, 0, 32'h8000_0000, 0, 1, 0, 0);
    idle(1);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);

    // Stale-response sequence: 2 outstanding, ev with same-cycle req, 1 more req
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 32'h0000_4000, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // TLB refetch target wraps
    drive(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 0, 0);
    idle(1);

    // Back-to-back: new event on the accept cycle
    drive(0, 0, 1, 0, 32'hA000_0040, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 32'h0000_1000, 1, 0, 0);
    idle(0);
    idle(1);
    drain();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1);
    end
    drain();
    repeat (3) idle(1);
    @(negedge clk);
    #3;
    check("leftover_expectations", cyc_q.size() + acc_q.size() + disc_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
